// File: rtl/toggle_rate_meter_pkg.sv
// Shared FSM state type and sizing helpers for toggle_rate_meter.
// Optional feature macro used by the top level: TOGGLE_METER_STUCK_DET_EN.
package toggle_rate_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    // Wide enough to count up to SYNC_STAGES (max 4) while arming.
    localparam int ARM_CNT_W = 3;

    function automatic int win_cnt_w(input int window);
        return $clog2(window);
    endfunction

endpackage

// File: rtl/toggle_rate_meter_sync.sv
// Input synchronizer for the asynchronous toggle line plus a history flop;
// any change of the synchronized level is reported as a one-cycle edge.
module toggle_sync
    import toggle_rate_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tog_in,
    output logic sync_out,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign edge_pulse = sync_out ^ hist_q;

endmodule

// File: rtl/toggle_rate_meter.sv
// Counts both edges of a synchronized toggle line over a fixed gate window.
// Define TOGGLE_METER_STUCK_DET_EN to add the stuck_o / stuck_level_o outputs.
module toggle_rate_meter
    import toggle_rate_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WINDOW      = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    input  logic             enable,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             sat_o
`ifdef TOGGLE_METER_STUCK_DET_EN
    ,
    output logic             stuck_o,
    output logic             stuck_level_o
`endif
);

    localparam int                   WIN_W    = win_cnt_w(WINDOW);
    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [ARM_CNT_W-1:0] ARM_LAST = ARM_CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    state_t               state, state_nxt;
    logic [ARM_CNT_W-1:0] arm_cnt;
    logic [WIN_W-1:0]     win_cnt;
    logic [CNT_W-1:0]     edge_cnt;
    logic                 sat_flag;
    logic [CNT_W:0]       acc;
    logic                 sat_nxt;
    logic                 sync_out;
    logic                 edge_pulse;

    // Returns {reached_max, next_count}; the count sticks at its maximum.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             inc);
        logic [CNT_W-1:0] nxt;
        nxt = (inc && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
        return {(nxt == CNT_MAX), nxt};
    endfunction

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .tog_in     (tog_in),
        .sync_out   (sync_out),
        .edge_pulse (edge_pulse)
    );

    assign acc     = sat_inc(edge_cnt, edge_pulse);
    assign sat_nxt = sat_flag | acc[CNT_W];
    assign busy_o  = (state == ARM) || (state == MEASURE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = ARM;
            ARM:     if (arm_cnt == ARM_LAST) state_nxt = MEASURE;
            MEASURE: if (win_cnt == WIN_LAST) state_nxt = REPORT;
            REPORT:  state_nxt = enable ? MEASURE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are registered on the last MEASURE cycle so they are visible
    // during REPORT, including any edge that lands in that final cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt  <= '0;
            win_cnt  <= '0;
            edge_cnt <= '0;
            sat_flag <= 1'b0;
            count_o  <= '0;
            valid_o  <= 1'b0;
            sat_o    <= 1'b0;
`ifdef TOGGLE_METER_STUCK_DET_EN
            stuck_o       <= 1'b0;
            stuck_level_o <= 1'b0;
`endif
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: arm_cnt <= '0;
                ARM: begin
                    arm_cnt  <= arm_cnt + ARM_CNT_W'(1);
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                    sat_flag <= 1'b0;
                end
                MEASURE: begin
                    win_cnt  <= win_cnt + WIN_W'(1);
                    edge_cnt <= acc[CNT_W-1:0];
                    sat_flag <= sat_nxt;
                    if (win_cnt == WIN_LAST) begin
                        valid_o <= 1'b1;
                        count_o <= acc[CNT_W-1:0];
                        sat_o   <= sat_nxt;
`ifdef TOGGLE_METER_STUCK_DET_EN
                        stuck_o       <= (acc[CNT_W-1:0] == '0);
                        stuck_level_o <= sync_out;
`endif
                    end
                end
                REPORT: begin
                    arm_cnt  <= '0;
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                    sat_flag <= 1'b0;
                end
                default: arm_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_rate_meter.sv
// Directed bench for toggle_rate_meter: a default-sized instance and a small
// saturating instance, checked with immediate assertions.
module tb_toggle_rate_meter;

    localparam int SA = 2, WA = 1024, CA = 16;
    localparam int SB = 3, WB = 64,   CB = 4;

    logic          clk;
    logic          rst_a, tog_a, en_a, valid_a, busy_a, sat_a;
    logic [CA-1:0] count_a;
    logic          rst_b, tog_b, en_b, valid_b, busy_b, sat_b;
    logic [CB-1:0] count_b;
`ifdef TOGGLE_METER_STUCK_DET_EN
    logic          stuck_a, stuck_level_a, stuck_b, stuck_level_b;
`endif

    int n_asserts;
    int n_fail;
    int per_a;
    int per_b;

    toggle_rate_meter #(.SYNC_STAGES(SA), .WINDOW(WA), .CNT_W(CA)) dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .tog_in  (tog_a),
        .enable  (en_a),
        .count_o (count_a),
        .valid_o (valid_a),
        .busy_o  (busy_a),
        .sat_o   (sat_a)
`ifdef TOGGLE_METER_STUCK_DET_EN
        ,
        .stuck_o       (stuck_a),
        .stuck_level_o (stuck_level_a)
`endif
    );

    toggle_rate_meter #(.SYNC_STAGES(SB), .WINDOW(WB), .CNT_W(CB)) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .tog_in  (tog_b),
        .enable  (en_b),
        .count_o (count_b),
        .valid_o (valid_b),
        .busy_o  (busy_b),
        .sat_o   (sat_b)
`ifdef TOGGLE_METER_STUCK_DET_EN
        ,
        .stuck_o       (stuck_b),
        .stuck_level_o (stuck_level_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Toggle generators: level flips every per_x cycles, 0 means hold.
    initial begin : gen_a
        int c;
        c = 0;
        tog_a = 1'b0;
        forever begin
            @(negedge clk);
            if (per_a == 0) c = 0;
            else begin
                c++;
                if (c >= per_a) begin
                    tog_a = ~tog_a;
                    c = 0;
                end
            end
        end
    end

    initial begin : gen_b
        int c;
        c = 0;
        tog_b = 1'b0;
        forever begin
            @(negedge clk);
            if (per_b == 0) c = 0;
            else begin
                c++;
                if (c >= per_b) begin
                    tog_b = ~tog_b;
                    c = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input bit sel_b, input string tag, input int budget,
                              output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (((sel_b ? valid_b : valid_a) !== 1'b1) && (cycles < budget));
        check({tag, " valid"}, sel_b ? valid_b : valid_a, 1);
    endtask

    initial begin
        int cyc;
        int pulses;
        n_asserts = 0;
        n_fail    = 0;
        per_a = 0;
        per_b = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        en_a  = 1'b1;
        en_b  = 1'b0;
        repeat (3) @(negedge clk);
        check("b rst count", count_b, 0);
        check("b rst busy", busy_b, 0);
        rst_b = 1'b0;
        per_a = 8;
        repeat (5) @(negedge clk);
        check("a rst count", count_a, 0);
        check("a rst valid", valid_a, 0);
        check("a rst busy", busy_a, 0);
        check("a rst sat", sat_a, 0);

        // Instance A: back-to-back windows, toggle every 8 cycles.
        rst_a = 1'b0;
        wait_valid(0, "a first", 1100, cyc);
        check("a first latency", cyc, SA + WA + 2);
        check("a w1 count", count_a, 128);
        check("a w1 sat", sat_a, 0);
`ifdef TOGGLE_METER_STUCK_DET_EN
        check("a w1 stuck", stuck_a, 0);
`endif
        wait_valid(0, "a second", 1100, cyc);
        check("a report period", cyc, WA + 1);
        check("a w2 count", count_a, 128);
        check("a busy in report", busy_a, 0);

        // Drop enable in the middle of a window.
        repeat (300) @(negedge clk);
        en_a = 1'b0;
        check("a busy mid window", busy_a, 1);
        wait_valid(0, "a last", 1100, cyc);
        check("a last period", cyc, WA + 1 - 300);
        check("a last count", count_a, 128);
        @(negedge clk);
        check("a idle after last", busy_a, 0);
        check("a valid one cycle", valid_a, 0);
        pulses = 0;
        repeat (1100) begin
            @(negedge clk);
            if (valid_a === 1'b1) pulses++;
        end
        check("a no report when idle", pulses, 0);
        check("a count holds", count_a, 128);
        check("a still idle", busy_a, 0);

        // Reset at MEASURE cycle 500.
        en_a = 1'b1;
        repeat (SA + 1 + 1 + 500) @(negedge clk);
        check("a busy before rst", busy_a, 1);
        rst_a = 1'b1;
        @(negedge clk);
        check("a rst mid count", count_a, 0);
        check("a rst mid busy", busy_a, 0);
        check("a rst mid valid", valid_a, 0);
        rst_a = 1'b0;
        wait_valid(0, "a after rst", 1100, cyc);
        check("a after rst latency", cyc, SA + WA + 2);
        check("a after rst count", count_a, 128);
        en_a  = 1'b0;
        per_a = 0;

        // Instance B: saturation, then a static window.
        per_b = 2;
        en_b  = 1'b1;
        wait_valid(1, "b sat", 200, cyc);
        check("b latency", cyc, SB + WB + 2);
        check("b sat count", count_b, 15);
        check("b sat flag", sat_b, 1);
        per_b = 0;
        wait_valid(1, "b settle", 200, cyc);
        check("b settle period", cyc, WB + 1);
        wait_valid(1, "b static", 200, cyc);
        check("b static count", count_b, 0);
        check("b static sat", sat_b, 0);
`ifdef TOGGLE_METER_STUCK_DET_EN
        check("b static stuck", stuck_b, 1);
        check("b static level", stuck_level_b, tog_b);
`endif

        // Enable dropped mid-window on B.
        per_b = 2;
        repeat (20) @(negedge clk);
        en_b = 1'b0;
        wait_valid(1, "b last", 200, cyc);
        check("b last period", cyc, WB + 1 - 20);
        check("b last count", count_b, 15);
        check("b last sat", sat_b, 1);
        @(negedge clk);
        check("b idle after last", busy_b, 0);
        pulses = 0;
        repeat (200) begin
            @(negedge clk);
            if (valid_b === 1'b1) pulses++;
        end
        check("b no report when idle", pulses, 0);
        check("b count holds", count_b, 15);

        // Input held high for a whole window, then toggling resumes.
        per_b = 0;
        tog_b = 1'b1;
        en_b  = 1'b1;
        wait_valid(1, "b held", 200, cyc);
        check("b held latency", cyc, SB + WB + 2);
        check("b held count", count_b, 0);
        check("b held sat", sat_b, 0);
`ifdef TOGGLE_METER_STUCK_DET_EN
        check("b held stuck", stuck_b, 1);
        check("b held level", stuck_level_b, 1);
`endif
        per_b = 2;
        wait_valid(1, "b resumed", 200, cyc);
        check("b resumed period", cyc, WB + 1);
        check("b resumed count", count_b, 15);
`ifdef TOGGLE_METER_STUCK_DET_EN
        check("b resumed stuck", stuck_b, 0);
`endif
        en_b  = 1'b0;
        per_b = 0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
